mul_share_ctrl: RTL
===================

Name: mul_share_ctrl

Overview:
- Sequential shift-and-add unsigned multiplier shared between two requesters, with a round-robin arbiter and an operand-capture handshake.
- Replaces per-requester combinational multipliers where area matters.
- Sits between two client blocks and a single iterative datapath.
- Fixed latency of N iterations per product, independent of operand values.

Parameters:
N, 3, operand width in bits (N >= 2); product width is 2N.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req0  input  1  requester 0 wants a product; held high until gnt0
a0  input  N  requester 0 multiplicand, bit 0 = LSB
b0  input  N  requester 0 multiplier, bit 0 = LSB
req1  input  1  requester 1 request
a1  input  N  requester 1 multiplicand
b1  input  N  requester 1 multiplier
gnt0  output  1  one-cycle pulse: operands of requester 0 captured
gnt1  output  1  one-cycle pulse: operands of requester 1 captured
busy  output  1  high while a product is in progress (MUL or DONE)
done  output  1  one-cycle pulse: p valid for the served requester
done_id  output  1  requester served by the current/last done
p  output  2N  unsigned product; holds value until next done

Behaviour:
- All outputs and internal state are registered. Synchronous reset (rst=1 at a rising edge) sets:
  - state=IDLE; gnt0=gnt1=busy=done=done_id=0; p=0
  - accumulator, operand and iteration-count registers = 0
  - last-served pointer = 1, so requester 0 wins the first tie.
- States are IDLE, MUL and DONE.
- IDLE:
  - If req0|req1 at an edge, pick a winner:
    - only one requesting -> that requester
    - both requesting -> the one that is not last-served
  - At that same edge: capture the winner's a into the multiplicand register (zero-extended to 2N) and its b into the multiplier register. Clear the accumulator and set the iteration count to 0. Pulse gnt of the winner for exactly one cycle. Set busy=1, update the last-served pointer, go to MUL.
  - No request: stay in IDLE, outputs unchanged (p holds).
- MUL, one iteration per edge:
  - If the multiplier LSB is 1, accumulator += multiplicand (2N-bit, no overflow possible).
  - Then multiplicand <<= 1, multiplier >>= 1, count += 1.
  - On the edge completing iteration N: p <= final accumulator, done <= 1, done_id <= winner, go to DONE.
- DONE:
  - Lasts exactly one cycle; done=1 and busy=1 during it.
  - Next edge: done <= 0, busy <= 0, go to IDLE.
- Timing with the capture edge as E0:
  - gnt visible in the cycle after E0.
  - done and p visible after edge E(N); back in IDLE after E(N+1).
  - Earliest next capture is E(N+2), so throughput is one product per N+2 cycles.
- Requests arriving during MUL/DONE are not granted and not lost: the requester holds req and is arbitrated in IDLE.
- A requester that drops req before gnt is simply not served. No partial capture.
- A requester that keeps req high after gnt is treated as a new request at the next IDLE arbitration.
- Operand changes after gnt have no effect on the product in progress.
- Zero operands still take the full N iterations (fixed latency); p=0.
- Max operands give p = (2^N-1)^2, e.g. 49 for N=3.
- Reset asserted mid-operation aborts immediately:
  - no done pulse
  - p cleared to 0
  - last-served pointer returns to 1
  - state returns to IDLE
- gnt0 and gnt1 are never high together; at most one done per gnt.

Test Plan:
- Reset, then req0=1 with a0=6 (110), b0=5 (101), N=3 -> gnt0 one cycle after the capture edge; done=1 three cycles later; p=30, done_id=0; busy high for 4 cycles.
- req1 only, a1=7, b1=7 -> gnt1 pulse; done with p=49, done_id=1; gnt0 never asserts.
- req0 and req1 both high continuously (a0=2,b0=3; a1=4,b1=5), starting from reset -> serve order is 0,1,0,1; p alternates 6,20; each done is N+2=5 cycles apart.
- a0=0, b0=7 -> done still arrives exactly N cycles after gnt, p=0; then a0=7, b0=0 -> p=0 with the same latency.
- Start a0=7, b0=7, assert rst for one cycle during MUL iteration 2 -> no done pulse; p=0, busy=0; next req0 with a0=3, b0=3 is granted first and gives p=9.
- During MUL, change a0/b0 and raise req1 -> the in-flight result equals the captured operands; req1 is granted only at the first IDLE edge after DONE.

Source files
------------

// File: rtl/mul_share_ctrl.sv
// Shared iterative shift-and-add unsigned multiplier serving two requesters.
// A round-robin arbiter picks one requester in IDLE and captures its operands.
// The multiplier then runs N add/shift iterations and pulses done for one cycle.
module mul_share_ctrl #(
    parameter int N = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic [N-1:0]   a0,
    input  logic [N-1:0]   b0,
    input  logic           req1,
    input  logic [N-1:0]   a1,
    input  logic [N-1:0]   b1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           busy,
    output logic           done,
    output logic           done_id,
    output logic [2*N-1:0] p
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t         state, state_nx;
    logic [2*N-1:0] mcand, mcand_nx;
    logic [2*N-1:0] acc, acc_nx, acc_sum;
    logic [N-1:0]   mplier, mplier_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           last, last_nx;
    logic           cur, cur_nx;
    logic           pick1;
    logic           gnt0_nx, gnt1_nx, busy_nx, done_nx, done_id_nx;
    logic [2*N-1:0] p_nx;

    // State, datapath and output registers; reset also aborts any product in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            cnt     <= '0;
            last    <= 1'b1;
            cur     <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            p       <= '0;
        end else begin
            state   <= state_nx;
            mcand   <= mcand_nx;
            acc     <= acc_nx;
            mplier  <= mplier_nx;
            cnt     <= cnt_nx;
            last    <= last_nx;
            cur     <= cur_nx;
            gnt0    <= gnt0_nx;
            gnt1    <= gnt1_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            done_id <= done_id_nx;
            p       <= p_nx;
        end
    end

    // Next-state, arbitration and one add/shift iteration per MUL cycle
    always_comb begin
        state_nx   = state;
        mcand_nx   = mcand;
        acc_nx     = acc;
        mplier_nx  = mplier;
        cnt_nx     = cnt;
        last_nx    = last;
        cur_nx     = cur;
        gnt0_nx    = 1'b0;
        gnt1_nx    = 1'b0;
        busy_nx    = busy;
        done_nx    = 1'b0;
        done_id_nx = done_id;
        p_nx       = p;
        // requester 1 wins when alone, or on a tie when requester 0 was served last
        pick1      = req1 & (~req0 | ~last);
        acc_sum    = acc + (mplier[0] ? mcand : '0);

        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    mcand_nx  = pick1 ? {{N{1'b0}}, a1} : {{N{1'b0}}, a0};
                    mplier_nx = pick1 ? b1 : b0;
                    acc_nx    = '0;
                    cnt_nx    = '0;
                    gnt0_nx   = ~pick1;
                    gnt1_nx   = pick1;
                    busy_nx   = 1'b1;
                    last_nx   = pick1;
                    cur_nx    = pick1;
                    state_nx  = MUL;
                end
            end
            MUL: begin
                acc_nx    = acc_sum;
                mcand_nx  = mcand << 1;
                mplier_nx = mplier >> 1;
                cnt_nx    = cnt + CW'(1);
                if (cnt == CW'(N - 1)) begin
                    p_nx       = acc_sum;
                    done_nx    = 1'b1;
                    done_id_nx = cur;
                    state_nx   = DONE;
                end
            end
            DONE: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
